// File: rtl/led_pkg.sv
// ---------------------------------------------------------------------------
// led_pkg
// Shared definitions for the board RGB LED output path.
//   CH_R / CH_G / CH_B : bit index of each channel in an RGB word
//   rgb_t              : 3-bit active-low colour word ([2]=R [1]=G [0]=B)
//   RGB_OFF            : all channels dark
//   ch_lit()           : decode one channel of an active-low colour word
// ---------------------------------------------------------------------------
package led_pkg;

    localparam int CH_R = 2;
    localparam int CH_G = 1;
    localparam int CH_B = 0;

    typedef logic [2:0] rgb_t;

    localparam rgb_t RGB_OFF = 3'b111;

    // A channel is requested lit when its active-low bit is 0.
    function automatic logic ch_lit(input rgb_t word, input int ch);
        return (word[ch] == 1'b0);
    endfunction

endpackage : led_pkg

// File: rtl/rgb_fade_driver_pwm_channel.sv
// ---------------------------------------------------------------------------
// pwm_channel
// One LED channel: working duty ramp, per-period shadow duty and the PWM
// compare that produces the active-low LED drive.
//   clk        : system clock
//   rst        : synchronous, active-high reset
//   step       : one-cycle pulse, move duty one LSB toward target
//   pwm_cnt    : shared free-running PWM counter
//   period_end : high on the last cycle of a PWM period
//   target     : duty the ramp is heading for
//   led_n      : registered PWM output, active-low
//   busy       : working duty has not yet reached target
// ---------------------------------------------------------------------------
module pwm_channel #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                step,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic                period_end,
    input  logic [PWM_BITS-1:0] target,
    output logic                led_n,
    output logic                busy
);

    localparam logic [PWM_BITS-1:0] ONE_LSB = PWM_BITS'(1);

    logic [PWM_BITS-1:0] duty_r;
    logic [PWM_BITS-1:0] active_r;
    logic [PWM_BITS-1:0] duty_next_s;

    // Next working duty: one LSB toward target on a step, never past it.
    always_comb begin
        duty_next_s = duty_r;
        if (step) begin
            if (duty_r < target) begin
                duty_next_s = duty_r + ONE_LSB;
            end else if (duty_r > target) begin
                duty_next_s = duty_r - ONE_LSB;
            end else begin
                duty_next_s = duty_r;
            end
        end else begin
            duty_next_s = duty_r;
        end
    end

    // Working duty register.
    always_ff @(posedge clk) begin
        if (rst) begin
            duty_r <= '0;
        end else begin
            duty_r <= duty_next_s;
        end
    end

    // Shadow duty: only reloaded at the end of a period so a PWM period is
    // never cut short or stretched by a ramp step landing mid-period.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_r <= '0;
        end else if (period_end) begin
            active_r <= duty_r;
        end else begin
            active_r <= active_r;
        end
    end

    // PWM compare; an all-ones duty leaves one dark cycle per period, so
    // full-on can never be reached.
    always_ff @(posedge clk) begin
        if (rst) begin
            led_n <= 1'b1;
        end else begin
            led_n <= !(pwm_cnt < active_r);
        end
    end

    assign busy = (duty_r != target);

endmodule : pwm_channel

// File: rtl/rgb_fade_driver.sv
// ---------------------------------------------------------------------------
// rgb_fade_driver
// Output stage between the colour sequencer and the board RGB LED pins.
// Each channel is PWM-driven at a runtime-capped brightness, and colour
// changes crossfade linearly instead of switching hard.
//   clk      : system clock
//   rst      : synchronous, active-high reset
//   rgb_req  : requested colour, active-low, [2]=R [1]=G [0]=B
//   enable   : 1 = honour rgb_req, 0 = fade every channel to off
//   max_duty : duty applied to every lit channel
//   rgb_out  : PWM LED drive, active-low, same bit order as rgb_req
//   fading   : some channel's working duty still differs from its target
// ---------------------------------------------------------------------------
module rgb_fade_driver
    import led_pkg::*;
#(
    parameter int PWM_BITS   = 8,
    parameter int STEP_TICKS = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          rgb_req,
    input  logic                enable,
    input  logic [PWM_BITS-1:0] max_duty,
    output logic [2:0]          rgb_out,
    output logic                fading
);

    localparam int STEP_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_TICKS - 1);
    localparam logic [STEP_W-1:0]   STEP_ONE  = STEP_W'(1);
    localparam logic [PWM_BITS-1:0] PWM_LAST  = '1;
    localparam logic [PWM_BITS-1:0] PWM_ONE   = PWM_BITS'(1);

    rgb_t                req_q;
    logic                en_q;
    logic [PWM_BITS-1:0] max_q;

    logic [STEP_W-1:0]   step_cnt_r;
    logic [PWM_BITS-1:0] pwm_cnt_r;

    logic                step_s;
    logic                period_end_s;
    logic [PWM_BITS-1:0] target_s [3];
    logic [2:0]          busy_s;

    // Input register; nothing downstream looks at the raw inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q <= RGB_OFF;
            en_q  <= 1'b0;
            max_q <= '0;
        end else begin
            req_q <= rgb_req;
            en_q  <= enable;
            max_q <= max_duty;
        end
    end

    // Ramp step timer; step_s fires on the wrap cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_cnt_r <= '0;
        end else if (step_s) begin
            step_cnt_r <= '0;
        end else begin
            step_cnt_r <= step_cnt_r + STEP_ONE;
        end
    end

    // Free-running PWM counter, wraps naturally at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt_r <= '0;
        end else begin
            pwm_cnt_r <= pwm_cnt_r + PWM_ONE;
        end
    end

    assign step_s       = (step_cnt_r == STEP_LAST);
    assign period_end_s = (pwm_cnt_r == PWM_LAST);

    // Per-channel targets; an all-lit request (sequencer error colour) is
    // deliberately honoured and lights all three channels.
    always_comb begin
        for (int c = 0; c < 3; c++) begin
            if (en_q && ch_lit(req_q, c)) begin
                target_s[c] = max_q;
            end else begin
                target_s[c] = '0;
            end
        end
    end

    for (genvar c = 0; c < 3; c++) begin : g_ch
        pwm_channel #(
            .PWM_BITS (PWM_BITS)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .step       (step_s),
            .pwm_cnt    (pwm_cnt_r),
            .period_end (period_end_s),
            .target     (target_s[c]),
            .led_n      (rgb_out[c]),
            .busy       (busy_s[c])
        );
    end

    assign fading = |busy_s;

endmodule : rgb_fade_driver

// File: tb/tb_rgb_fade_driver.sv
// ---------------------------------------------------------------------------
// tb_rgb_fade_driver
// Self-checking bench: a time-based reference model (phase derived from the
// number of cycles since reset) is compared against rgb_out / fading every
// cycle, with directed scenarios and literal expectations, then random
// stimulus including occasional mid-fade resets.
// ---------------------------------------------------------------------------
module tb_rgb_fade_driver;

    localparam int PW     = 4;
    localparam int STEP   = 4;
    localparam int PERIOD = 1 << PW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [2:0]    rgb_req = 3'b000;
    logic          enable = 1'b1;
    logic [PW-1:0] max_duty = '0;
    logic [2:0]    rgb_out;
    logic          fading;

    int checks = 0;
    int failures = 0;

    rgb_fade_driver #(
        .PWM_BITS   (PW),
        .STEP_TICKS (STEP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rgb_req  (rgb_req),
        .enable   (enable),
        .max_duty (max_duty),
        .rgb_out  (rgb_out),
        .fading   (fading)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: t = cycles since reset; PWM phase is t mod period,
    // a ramp step happens when t mod STEP == STEP-1.
    // ------------------------------------------------------------------
    bit       m_valid = 1'b0;
    int       t;
    int       m_duty [3];
    int       m_act  [3];
    logic [2:0] m_out;
    logic [2:0] m_req;
    bit       m_en;
    int       m_max;

    function automatic int tgt(input int c);
        return (m_en && !m_req[c]) ? m_max : 0;
    endfunction

    function automatic bit m_fading();
        bit f = 1'b0;
        for (int c = 0; c < 3; c++) if (m_duty[c] != tgt(c)) f = 1'b1;
        return f;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b1;
            t = 0;
            for (int c = 0; c < 3; c++) begin m_duty[c] = 0; m_act[c] = 0; end
            m_out = 3'b111; m_req = 3'b111; m_en = 1'b0; m_max = 0;
        end else if (m_valid) begin
            int ph;
            int nd [3];
            ph = t % PERIOD;
            for (int c = 0; c < 3; c++) begin
                m_out[c] = !(ph < m_act[c]);
                nd[c] = m_duty[c];
                if ((t % STEP) == STEP - 1) begin
                    if (m_duty[c] < tgt(c)) nd[c] = m_duty[c] + 1;
                    else if (m_duty[c] > tgt(c)) nd[c] = m_duty[c] - 1;
                end
            end
            if (ph == PERIOD - 1) for (int c = 0; c < 3; c++) m_act[c] = m_duty[c];
            for (int c = 0; c < 3; c++) m_duty[c] = nd[c];
            m_req = rgb_req; m_en = enable; m_max = int'(max_duty);
            t++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0d)", name, act, exp, t);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            check("rgb_out_model", int'(rgb_out), int'(m_out));
            check("fading_model", int'(fading), int'(m_fading()));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic set_in(input logic [2:0] r, input logic e, input int m);
        rgb_req = r; enable = e; max_duty = PW'(m);
    endtask

    // Wait (bounded) for fading to drop; returns cycles waited.
    task automatic wait_settle(input string name, input int bound, output int n);
        n = 0;
        tick(2); n = 2;
        while (fading !== 1'b0 && n < bound) begin tick(1); n++; end
        check(name, int'(n < bound), 1);
    endtask

    task automatic count_low(input int ch, output int lows);
        lows = 0;
        for (int i = 0; i < PERIOD; i++) begin
            @(negedge clk);
            if (rgb_out[ch] == 1'b0) lows++;
        end
        #1;
    endtask

    initial begin
        int n, lows;
        bit stuck;

        // 1. Reset with an all-lit request pending.
        set_in(3'b000, 1'b1, 15);
        rst = 1'b1;
        @(posedge clk); #1;
        check("reset_rgb_out", int'(rgb_out), 7);
        check("reset_fading", int'(fading), 0);
        tick(2);
        check("reset_rgb_out_hold", int'(rgb_out), 7);
        rst = 1'b0;

        // 2. Red at duty 8.
        set_in(3'b011, 1'b1, 8);
        wait_settle("red_settle_bound", 60, n);
        check("red_settle_le36", int'(n <= 36), 1);
        check("model_red_duty", m_duty[2], 8);
        check("model_green_duty", m_duty[1], 0);
        tick(PERIOD + 1);
        count_low(2, lows);
        check("red_low_count", lows, 8);
        check("gb_dark", int'(rgb_out[1:0]), 3);

        // 3. Crossfade red -> green.
        set_in(3'b101, 1'b1, 8);
        tick(2 + STEP);
        check("xfade_fading", int'(fading), 1);
        wait_settle("xfade_settle_bound", 60, n);
        check("model_xfade_red", m_duty[2], 0);
        check("model_xfade_green", m_duty[1], 8);
        tick(PERIOD + 1);
        count_low(1, lows);
        check("green_low_count", lows, 8);

        // 4/5. Back to red, then fade everything off with enable low.
        set_in(3'b011, 1'b1, 8);
        wait_settle("red_again_bound", 60, n);
        set_in(3'b011, 1'b0, 8);
        wait_settle("disable_settle_bound", 60, n);
        check("model_disable_red", m_duty[2], 0);
        tick(PERIOD + 2);
        stuck = 1'b1;
        for (int i = 0; i < 2 * PERIOD; i++) begin
            @(negedge clk);
            if (rgb_out !== 3'b111) stuck = 1'b0;
        end
        #1;
        check("disabled_dark", int'(stuck), 1);
        set_in(3'b011, 1'b1, 8);
        wait_settle("reenable_settle_bound", 60, n);
        check("model_reenable_red", m_duty[2], 8);

        // 6. Reset mid-fade at red duty 5 rising.
        rst = 1'b1; tick(1); rst = 1'b0;
        set_in(3'b011, 1'b1, 8);
        n = 0;
        while (m_duty[2] != 5 && n < 60) begin tick(1); n++; end
        check("reach_duty5", int'(n < 60), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midfade_rst_out", int'(rgb_out), 7);
        check("midfade_rst_fading", int'(fading), 0);
        rst = 1'b0;
        wait_settle("restart_settle_bound", 60, n);
        check("restart_le36", int'(n <= 36), 1);
        check("model_restart_red", m_duty[2], 8);

        // Random stimulus, with occasional reset pulses and max changes.
        for (int k = 0; k < 60; k++) begin
            set_in(3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
                   int'($urandom_range(0, PERIOD - 1)));
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1; tick(1); rst = 1'b0;
            end
            tick(int'($urandom_range(1, 50)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_rgb_fade_driver
